// File: rtl/uart_packet_tx.sv
// Packet serializer: accepts a 40-bit packet over a four-phase send/tx_ack
// handshake and shifts it out as five 8N1 frames, most significant byte first.
module uart_packet_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [39:0] din,
  input  logic        send,
  output logic        tx_ack,
  output logic        txd,
  output logic        busy
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]    state;
  logic [BW-1:0] baudcnt;
  logic [2:0]    bitcnt;
  logic [2:0]    bytecnt;
  logic [39:0]   shadow;
  logic [7:0]    cur_byte;
  logic [2:0]    bit_nxt;
  logic          accept;
  logic          bit_end;

  // Handshake: valid = send (level, held by the endpoint), ready = IDLE with
  // the previous handshake fully closed (tx_ack low). Transfer on the edge
  // where both hold; tx_ack then stays high until send is seen low.
  assign accept  = (state == IDLE) && send && !tx_ack;
  assign bit_end = (baudcnt == BAUD_MAX);
  assign bit_nxt = bitcnt + 3'd1;

  always_comb begin
    cur_byte = shadow[39:32];
    case (bytecnt)
      3'd1:    cur_byte = shadow[31:24];
      3'd2:    cur_byte = shadow[23:16];
      3'd3:    cur_byte = shadow[15:8];
      3'd4:    cur_byte = shadow[7:0];
      default: cur_byte = shadow[39:32];
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= IDLE;
      baudcnt <= '0;
      bitcnt  <= '0;
      bytecnt <= '0;
      shadow  <= '0;
      tx_ack  <= 1'b0;
      busy    <= 1'b0;
      txd     <= 1'b1;
    end else begin
      if (accept) begin
        tx_ack <= 1'b1;
      end else if (tx_ack && !send) begin
        tx_ack <= 1'b0;
      end

      // txd is loaded with the level of the state being entered, so the
      // line changes exactly on bit boundaries and never glitches.
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (accept) begin
            shadow  <= din;
            bytecnt <= '0;
            bitcnt  <= '0;
            baudcnt <= '0;
            busy    <= 1'b1;
            state   <= START;
            txd     <= 1'b0;
          end
        end
        default: begin
          baudcnt <= bit_end ? '0 : baudcnt + 1'b1;
          if (bit_end) begin
            case (state)
              START: begin
                state <= DATA;
                txd   <= cur_byte[0];
              end
              DATA: begin
                if (bitcnt == 3'd7) begin
                  state  <= STOP;
                  bitcnt <= '0;
                  txd    <= 1'b1;
                end else begin
                  bitcnt <= bit_nxt;
                  txd    <= cur_byte[bit_nxt];
                end
              end
              STOP: begin
                if (bytecnt == 3'd4) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  txd   <= 1'b1;
                end else begin
                  bytecnt <= bytecnt + 3'd1;
                  state   <= START;
                  txd     <= 1'b0;
                end
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_packet_tx.sv
// Bench for uart_packet_tx: two instances (divisor 4 and divisor 2) driven by
// directed steps; a UART receiver model checks bytes against a queue.
module tb_uart_packet_tx;

  logic        clk;
  logic        clr;
  logic [39:0] din4, din2;
  logic        send4, send2;
  logic        tx_ack4, tx_ack2;
  logic        txd4, txd2;
  logic        busy4, busy2;

  logic        sel;
  logic        obs_txd, obs_busy, obs_ack;
  int          per;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  uart_packet_tx #(.CLKS_PER_BIT(4)) u_dut4 (
    .clk(clk), .clr(clr), .din(din4), .send(send4),
    .tx_ack(tx_ack4), .txd(txd4), .busy(busy4)
  );

  uart_packet_tx #(.CLKS_PER_BIT(2)) u_dut2 (
    .clk(clk), .clr(clr), .din(din2), .send(send2),
    .tx_ack(tx_ack2), .txd(txd2), .busy(busy2)
  );

  assign obs_txd  = sel ? txd2    : txd4;
  assign obs_busy = sel ? busy2   : busy4;
  assign obs_ack  = sel ? tx_ack2 : tx_ack4;
  assign per      = sel ? 2 : 4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [39:0] observed, input logic [39:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic push_packet(input logic [39:0] p);
    for (int n = 0; n < 5; n++) exp_q.push_back(p[39 - 8*n -: 8]);
  endtask

  // Called at the negedge following the accept edge; returns at the negedge
  // following the edge where busy should have dropped.
  task automatic recv_packet(input string tag);
    logic [7:0] got;
    logic [7:0] expb;
    bit frame_ok;
    bit busy_ok;
    busy_ok = 1'b1;
    for (int f = 0; f < 5; f++) begin
      frame_ok = 1'b1;
      got = 8'h00;
      for (int b = 0; b < 10; b++) begin
        for (int c = 0; c < per; c++) begin
          if (obs_busy !== 1'b1) busy_ok = 1'b0;
          if (b == 0 && obs_txd !== 1'b0) frame_ok = 1'b0;
          if (b == 9 && obs_txd !== 1'b1) frame_ok = 1'b0;
          if (b >= 1 && b <= 8) begin
            if (c == 0) got[b-1] = obs_txd;
            else if (obs_txd !== got[b-1]) frame_ok = 1'b0;
          end
          @(negedge clk);
        end
      end
      if (exp_q.size() == 0) begin
        chk({tag, "_sb_empty"}, 40'(got), 40'h1_0000_0000);
      end else begin
        expb = exp_q.pop_front();
        chk({tag, "_byte"}, 40'(got), 40'(expb));
      end
      chk({tag, "_framing"}, 40'(frame_ok), 40'd1);
    end
    chk({tag, "_busy_span"}, 40'(busy_ok), 40'd1);
    chk({tag, "_busy_end"}, 40'(obs_busy), 40'd0);
    chk({tag, "_txd_idle"}, 40'(obs_txd), 40'd1);
  endtask

  initial begin
    bit ack_seen;
    bit clr_ok;
    logic [39:0] rnd;
    clr = 1'b1; sel = 1'b0;
    send4 = 1'b0; din4 = '0;
    send2 = 1'b0; din2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_txd4", 40'(txd4), 40'd1);
    chk("rst_busy4", 40'(busy4), 40'd0);
    chk("rst_ack4", 40'(tx_ack4), 40'd0);
    chk("rst_txd2", 40'(txd2), 40'd1);
    clr = 1'b0;
    @(negedge clk);

    // Packet A with handshake timing, din change after accept, then a
    // pending request raised while A is still busy.
    din4 = 40'h01_02_A5_F0_0F; send4 = 1'b1;
    push_packet(din4);
    @(negedge clk);
    chk("a_ack_rise", 40'(tx_ack4), 40'd1);
    chk("a_busy_rise", 40'(busy4), 40'd1);
    chk("a_start", 40'(txd4), 40'd0);
    fork
      recv_packet("a");
      begin
        @(negedge clk); din4 = 40'h0;
        @(negedge clk); send4 = 1'b0;
        chk("a_ack_held", 40'(tx_ack4), 40'd1);
        @(negedge clk);
        chk("a_ack_fall", 40'(tx_ack4), 40'd0);
        chk("a_ack_fall_midframe", 40'(busy4), 40'd1);
        repeat (60) @(negedge clk);
        din4 = 40'hFF_FFFF_FFFF; send4 = 1'b1;
        push_packet(din4);
        ack_seen = 1'b0;
        for (int i = 0; i < 400 && busy4; i++) begin
          if (tx_ack4 !== 1'b0) ack_seen = 1'b1;
          @(negedge clk);
        end
        chk("pend_no_ack", 40'(ack_seen), 40'd0);
      end
    join
    @(negedge clk);
    chk("pend_start_gap", 40'(txd4), 40'd0);
    chk("pend_ack", 40'(tx_ack4), 40'd1);
    send4 = 1'b0;
    recv_packet("b");

    // Reset during byte 2, bit 3; send stays high through and after clr.
    din4 = 40'hAA_AAAA_AAAA; send4 = 1'b1;
    @(negedge clk);
    chk("r_accept", 40'(tx_ack4), 40'd1);
    repeat (24 * 4 + 1) @(negedge clk);
    clr = 1'b1;
    #1;
    chk("r_txd", 40'(txd4), 40'd1);
    chk("r_busy", 40'(busy4), 40'd0);
    chk("r_ack", 40'(tx_ack4), 40'd0);
    clr_ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (tx_ack4 !== 1'b0 || txd4 !== 1'b1) clr_ok = 1'b0;
    end
    chk("r_held_in_reset", 40'(clr_ok), 40'd1);
    clr = 1'b0;
    push_packet(din4);
    @(negedge clk);
    chk("r_reaccept", 40'(tx_ack4), 40'd1);
    chk("r_restart", 40'(txd4), 40'd0);
    send4 = 1'b0;
    recv_packet("r");

    // Minimum divisor instance.
    sel = 1'b1;
    din2 = 40'h80_0000_0001; send2 = 1'b1;
    push_packet(din2);
    @(negedge clk);
    chk("m_ack_rise", 40'(tx_ack2), 40'd1);
    chk("m_start", 40'(txd2), 40'd0);
    send2 = 1'b0;
    recv_packet("m");

    // Random packet on the divisor-4 instance.
    sel = 1'b0;
    rnd = {8'($urandom_range(255, 0)), 32'($urandom)};
    din4 = rnd; send4 = 1'b1;
    push_packet(rnd);
    @(negedge clk);
    chk("x_ack_rise", 40'(tx_ack4), 40'd1);
    send4 = 1'b0;
    din4 = ~rnd;
    recv_packet("x");
    chk("sb_drained", 40'(exp_q.size()), 40'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
